hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 33 +++
 rtl/hazard_scoreboard_src_match.sv | 39 +++
 rtl/hazard_scoreboard.sv | 99 +++++++++
 tb/tb_hazard_scoreboard.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: operand-select stage indices,
// the in-flight tag record and the select-width helper.
package hazard_scoreboard_pkg;

    // Operand select codes; stage N of the tag pipeline forwards as code N.
    localparam int SEL_RF = 0;
    localparam int SEL_EX = 1;
    localparam int SEL_M1 = 2;

    // Widest register index a tag can carry; narrower indices are zero-extended.
    localparam int RW_MAX = 8;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic              valid;
        logic [RW_MAX-1:0] dst;
        logic              wr;
        logic              load;
    } tag_t;

    // Bits needed to encode n distinct select values (at least 1).
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        for (int k = 1; k < 31; k++) begin
            if ((1 << w) < n) begin
                w = k + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// Per-source match against the tag pipeline: picks the youngest producing
// stage and flags a load that cannot be forwarded yet.
module hz_src_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int RW  = 5,
    parameter int NST = 3,
    parameter int SW  = 2
) (
    input  logic             used,
    input  logic [RW-1:0]    idx,
    input  tag_t [NST:1]     tags,
    output logic [SW-1:0]    sel,
    output logic             hazard
);

    logic [NST:1] hit;

    // r0 is hard-wired, so it never matches anything in flight.
    generate
        for (genvar gi = 1; gi <= NST; gi++) begin : g_hit
            assign hit[gi] = used && (idx != '0) && tags[gi].valid && tags[gi].wr
                             && (tags[gi].dst == RW_MAX'(idx));
        end
    endgenerate

    // Scan oldest to youngest so the youngest hit overrides; only WB may feed a load result.
    always_comb begin
        sel    = SW'(SEL_RF);
        hazard = 1'b0;
        for (int i = NST; i >= 1; i--) begin
            if (hit[i]) begin
                sel    = SW'(i);
                hazard = tags[i].load && (i < NST);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight destinations from EX to WB, drives the
// operand forwarding selects, load-use stall, freeze and performance counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int RW      = 5,
    parameter int MEM_LAT = 1,
    parameter int CW      = 16,
    localparam int SW     = sel_width(MEM_LAT + 3)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic [RW-1:0] id_dst,
    input  logic          id_wr,
    input  logic          id_load,
    input  logic          mem_busy,
    output logic [SW-1:0] fwd_a,
    output logic [SW-1:0] fwd_b,
    output logic          stall,
    output logic          freeze,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] fwd_cnt
);

    localparam int NST = MEM_LAT + 2;

    tag_t [NST:1] tags;
    logic         haz_a;
    logic         haz_b;
    logic         fwd_any;

    hz_src_match #(.RW(RW), .NST(NST), .SW(SW)) u_match_rs (
        .used   (id_rs_used),
        .idx    (id_rs),
        .tags   (tags),
        .sel    (fwd_a),
        .hazard (haz_a)
    );

    hz_src_match #(.RW(RW), .NST(NST), .SW(SW)) u_match_rt (
        .used   (id_rt_used),
        .idx    (id_rt),
        .tags   (tags),
        .sel    (fwd_b),
        .hazard (haz_b)
    );

    // A frozen back end cannot make progress, so a stall would be meaningless.
    assign freeze  = mem_busy;
    assign stall   = id_valid && (haz_a || haz_b) && !mem_busy;
    assign fwd_any = (fwd_a != '0) || (fwd_b != '0);

    // EX captures the ID instruction, or a bubble while stalling; holds under freeze.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tags[SEL_EX] <= '0;
        end else if (!mem_busy) begin
            if (stall) begin
                tags[SEL_EX] <= '0;
            end else begin
                tags[SEL_EX] <= '{valid: id_valid, dst: RW_MAX'(id_dst), wr: id_wr, load: id_load};
            end
        end
    end

    generate
        for (genvar gi = SEL_M1; gi <= NST; gi++) begin : g_stage
            // Later stages simply advance one step per unfrozen cycle.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    tags[gi] <= '0;
                end else if (!mem_busy) begin
                    tags[gi] <= tags[gi-1];
                end
            end
        end
    endgenerate

    // Saturating stall / forward counters, frozen along with the pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (!mem_busy) begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (id_valid && !stall && fwd_any && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: a MEM_LAT=1/CW=16 instance and a
// MEM_LAT=2/CW=4 instance share stimulus; each record names the instance it checks.
module tb_hazard_scoreboard;

    typedef struct {
        string       nm;
        int          d;
        logic        r;
        logic        v;
        logic [4:0]  rs;
        logic        ru;
        logic [4:0]  rt;
        logic        tu;
        logic [4:0]  dst;
        logic        wr;
        logic        ld;
        logic        bz;
        logic [2:0]  fa;
        logic [2:0]  fb;
        logic        st;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs_used, id_rt_used, id_wr, id_load, mem_busy;
    logic [4:0] id_rs, id_rt, id_dst;

    logic [1:0]  a_fa, a_fb;
    logic        a_stall, a_freeze;
    logic [15:0] a_sc, a_fc;
    logic [2:0]  b_fa, b_fb;
    logic        b_stall, b_freeze;
    logic [3:0]  b_sc, b_fc;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.RW(5), .MEM_LAT(1), .CW(16)) u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
        .id_wr(id_wr), .id_load(id_load), .mem_busy(mem_busy),
        .fwd_a(a_fa), .fwd_b(a_fb), .stall(a_stall), .freeze(a_freeze),
        .stall_cnt(a_sc), .fwd_cnt(a_fc)
    );

    hazard_scoreboard #(.RW(5), .MEM_LAT(2), .CW(4)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
        .id_wr(id_wr), .id_load(id_load), .mem_busy(mem_busy),
        .fwd_a(b_fa), .fwd_b(b_fb), .stall(b_stall), .freeze(b_freeze),
        .stall_cnt(b_sc), .fwd_cnt(b_fc)
    );

    function automatic vec_t mk(string nm, int d, logic r, logic v,
                                logic [4:0] rs, logic ru, logic [4:0] rt, logic tu,
                                logic [4:0] dst, logic wr, logic ld, logic bz,
                                logic [2:0] fa, logic [2:0] fb, logic st,
                                logic [15:0] sc, logic [15:0] fc);
        vec_t x;
        x.nm = nm; x.d = d; x.r = r; x.v = v; x.rs = rs; x.ru = ru; x.rt = rt; x.tu = tu;
        x.dst = dst; x.wr = wr; x.ld = ld; x.bz = bz;
        x.fa = fa; x.fb = fb; x.st = st; x.sc = sc; x.fc = fc;
        return x;
    endfunction

    task automatic check_out();
        vec_t        e;
        logic [2:0]  fa, fb;
        logic        st, fz;
        logic [15:0] sc, fc;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
            return;
        end
        e = exp_q.pop_front();
        if (e.d == 0) begin
            fa = {1'b0, a_fa}; fb = {1'b0, a_fb}; st = a_stall; fz = a_freeze; sc = a_sc; fc = a_fc;
        end else begin
            fa = b_fa; fb = b_fb; st = b_stall; fz = b_freeze; sc = {12'd0, b_sc}; fc = {12'd0, b_fc};
        end
        if (fa !== e.fa || fb !== e.fb || st !== e.st || fz !== e.bz || sc !== e.sc || fc !== e.fc) begin
            n_bad++;
            $display("FAIL %s: got fa=%0d fb=%0d stall=%0b freeze=%0b scnt=%0d fcnt=%0d, required fa=%0d fb=%0d stall=%0b freeze=%0b scnt=%0d fcnt=%0d",
                     e.nm, fa, fb, st, fz, sc, fc, e.fa, e.fb, e.st, e.bz, e.sc, e.fc);
        end else begin
            $display("ok   %s: fa=%0d fb=%0d stall=%0b freeze=%0b scnt=%0d fcnt=%0d",
                     e.nm, fa, fb, st, fz, sc, fc);
        end
    endtask

    // Drive one cycle of stimulus after the edge, queue its expectation, check at the falling edge.
    task automatic run(input vec_t v);
        @(posedge clk);
        #1;
        rst        = v.r;
        id_valid   = v.v;
        id_rs      = v.rs;
        id_rs_used = v.ru;
        id_rt      = v.rt;
        id_rt_used = v.tu;
        id_dst     = v.dst;
        id_wr      = v.wr;
        id_load    = v.ld;
        mem_busy   = v.bz;
        exp_q.push_back(v);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        vec_t        v;
        logic [15:0] sc_m, fc_m;
        logic [2:0]  fa_e;
        logic        st_e;

        rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_used = 1'b0;
        id_rt_used = 1'b0; id_dst = '0; id_wr = 1'b0; id_load = 1'b0; mem_busy = 1'b0;
        #3 rst = 1'b0;

        // MEM_LAT=1 instance: forwarding from each stage, youngest wins, r0, load-use.
        //                  name               d  r  v  rs ru rt tu dst wr ld bz  fa fb st sc fc
        tbl.push_back(mk("a_reset",          0, 0, 1, 3, 1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("a_alu_r3",         0, 1, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("a_fwd_ex",         0, 1, 1, 3, 1, 0, 0, 6, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("a_idle_decode",    0, 1, 0, 3, 1, 6, 1, 0, 0, 0, 0, 2, 1, 0, 0, 1));
        tbl.push_back(mk("a_fwd_wb",         0, 1, 1, 3, 1, 6, 1, 0, 0, 0, 0, 3, 2, 0, 0, 1));
        tbl.push_back(mk("a_retired",        0, 1, 1, 6, 1, 3, 1, 0, 0, 0, 0, 3, 0, 0, 0, 2));
        tbl.push_back(mk("a_alu_r4_first",   0, 1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk("a_alu_r4_second",  0, 1, 1, 4, 1, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, 3));
        tbl.push_back(mk("a_youngest_wins",  0, 1, 1, 4, 1, 4, 1, 0, 0, 0, 0, 1, 1, 0, 0, 4));
        tbl.push_back(mk("a_load_r0",        0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk("a_read_r0",        0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk("a_load_r7",        0, 1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk("a_lu_stall_ex",    0, 1, 1, 7, 1, 0, 0, 2, 1, 0, 0, 1, 0, 1, 0, 5));
        tbl.push_back(mk("a_lu_stall_m1",    0, 1, 1, 7, 1, 0, 0, 2, 1, 0, 0, 2, 0, 1, 1, 5));
        tbl.push_back(mk("a_lu_fwd_wb",      0, 1, 1, 7, 1, 0, 0, 2, 1, 0, 0, 3, 0, 0, 2, 5));
        tbl.push_back(mk("a_after_lu",       0, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 6));
        // MEM_LAT=2 instance: load-use on rt, then a stall interrupted by a 2-cycle freeze.
        tbl.push_back(mk("b_reset",          1, 0, 1, 5, 1, 5, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("b_load_r5",        1, 1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("b_lu_ex",          1, 1, 1, 1, 0, 5, 1, 8, 1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk("b_lu_m1",          1, 1, 1, 1, 0, 5, 1, 8, 1, 0, 0, 0, 2, 1, 1, 0));
        tbl.push_back(mk("b_lu_m2",          1, 1, 1, 1, 0, 5, 1, 8, 1, 0, 0, 0, 3, 1, 2, 0));
        tbl.push_back(mk("b_lu_fwd_wb",      1, 1, 1, 1, 0, 5, 1, 8, 1, 0, 0, 0, 4, 0, 3, 0));
        tbl.push_back(mk("b_idle",           1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1));
        tbl.push_back(mk("b_load_r9",        1, 1, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 3, 1));
        tbl.push_back(mk("b_lu9_stall",      1, 1, 1, 9, 1, 0, 0,10, 1, 0, 0, 1, 0, 1, 3, 1));
        tbl.push_back(mk("b_freeze_1",       1, 1, 1, 9, 1, 0, 0,10, 1, 0, 1, 2, 0, 0, 4, 1));
        tbl.push_back(mk("b_freeze_2",       1, 1, 1, 9, 1, 0, 0,10, 1, 0, 1, 2, 0, 0, 4, 1));
        tbl.push_back(mk("b_resume_m1",      1, 1, 1, 9, 1, 0, 0,10, 1, 0, 0, 2, 0, 1, 4, 1));
        tbl.push_back(mk("b_resume_m2",      1, 1, 1, 9, 1, 0, 0,10, 1, 0, 0, 3, 0, 1, 5, 1));
        tbl.push_back(mk("b_lu9_fwd_wb",     1, 1, 1, 9, 1, 0, 0,10, 1, 0, 0, 4, 0, 0, 6, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i]);
        end

        // Back-to-back dependent loads on the MEM_LAT=2 instance: every fourth
        // cycle is accepted (forwarding from WB), the other three stall.
        run(mk("b_sat_reset", 1, 0, 1, 10, 1, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 0));
        sc_m = 0;
        fc_m = 0;
        for (int n = 0; n < 30; n++) begin
            if (n == 0) begin
                st_e = 1'b0; fa_e = 3'd0;
            end else if (n % 4 == 0) begin
                st_e = 1'b0; fa_e = 3'd4;
            end else begin
                st_e = 1'b1; fa_e = 3'(n % 4);
            end
            v = mk($sformatf("b_sat_cycle_%0d", n), 1, 1, 1, 10, 1, 0, 0, 10, 1, 1, 0,
                   fa_e, 3'd0, st_e, sc_m, fc_m);
            run(v);
            if (st_e && sc_m != 16'd15) sc_m = sc_m + 16'd1;
            if (!st_e && fa_e != 3'd0 && fc_m != 16'd15) fc_m = fc_m + 16'd1;
        end
        // Cycle 30 would stall; reset lands in the middle of it.
        run(mk("b_mid_stall_reset", 1, 0, 1, 10, 1, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 0));
        run(mk("b_post_reset_accept", 1, 1, 1, 10, 1, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 0));
        run(mk("b_post_reset_lu", 1, 1, 1, 10, 1, 0, 0, 10, 1, 1, 0, 1, 0, 1, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
